// File: rtl/reg_read_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_read_unit_pkg
// Description : Shared FSM state encodings and register-index constants for
//               the register read unit and the write-register selector.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_read_unit_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  // Register indices shared with the write-register selector.
  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [ADDR_W-1:0] REG_K    = 5'd24;
  localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    READ = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage
`default_nettype wire

// File: rtl/reg_read_unit_reg_array.sv
`default_nettype none
// ============================================================================
// Module      : reg_array
// Description : 32 x 32-bit register file, synchronous write, two
//               combinational read ports, asynchronous clear. Register 0 has
//               no storage and always reads as zero.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_array
  import reg_read_unit_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [NUM_REGS-1:0][DATA_W-1:0] w_regs;

  // Index 0 is hardwired, so writes addressed to it have nowhere to land.
  assign w_regs[REG_ZERO] = '0;

  generate
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
      logic [DATA_W-1:0] r_val;

      // One storage word, written when its index is addressed.
      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          r_val <= '0;
        end else if (we && (waddr == ADDR_W'(gi))) begin
          r_val <= wdata;
        end
      end

      assign w_regs[gi] = r_val;
    end
  endgenerate

  assign rdata_a = w_regs[raddr_a];
  assign rdata_b = w_regs[raddr_b];

endmodule
`default_nettype wire

// File: rtl/reg_read_unit.sv
`default_nettype none
// ============================================================================
// Module      : reg_read_unit
// Description : Three-state operand read unit. Latches rs/rt from the
//               instruction on an accepted request, reads both operands from
//               the register file one cycle later and flags the result with a
//               one-cycle rd_valid pulse.
//               Optional macro REG_BYPASS_EN: a write landing in the READ
//               cycle on a latched operand index is forwarded to the output.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_read_unit
  import reg_read_unit_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] instr,
  input  logic        rd_req,
  output logic        rd_ready,
  output logic        rd_valid,
  output logic [31:0] A_out,
  output logic [31:0] B_out,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data
);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_rs_l;
  logic [ADDR_W-1:0] r_rt_l;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic              r_valid;
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;
  logic [DATA_W-1:0] w_load_a;
  logic [DATA_W-1:0] w_load_b;
  logic              w_accept;
  logic              w_unused;

  // Only the operand fields of the instruction are consumed here.
  assign w_unused = ^{instr[31:26], instr[15:0]};

  reg_array u_reg_array (
    .CLK     (CLK),
    .RST     (RST),
    .we      (wr_en),
    .waddr   (wr_addr),
    .wdata   (wr_data),
    .raddr_a (r_rs_l),
    .raddr_b (r_rt_l),
    .rdata_a (w_rd_a),
    .rdata_b (w_rd_b)
  );

  assign rd_ready = (r_state == IDLE);
  assign w_accept = rd_ready && rd_req;

`ifdef REG_BYPASS_EN
  logic w_hit_a;
  logic w_hit_b;
  assign w_hit_a  = wr_en && (wr_addr != REG_ZERO) && (wr_addr == r_rs_l);
  assign w_hit_b  = wr_en && (wr_addr != REG_ZERO) && (wr_addr == r_rt_l);
  assign w_load_a = w_hit_a ? wr_data : w_rd_a;
  assign w_load_b = w_hit_b ? wr_data : w_rd_b;
`else
  // Without forwarding the outputs see the value stored before this edge.
  assign w_load_a = w_rd_a;
  assign w_load_b = w_rd_b;
`endif

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic; requests outside IDLE are ignored.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (rd_req) w_next = READ;
      READ:    w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Capture operand indices at acceptance so later instr changes are inert.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_rs_l <= '0;
      r_rt_l <= '0;
    end else if (w_accept) begin
      r_rs_l <= instr[25:21];
      r_rt_l <= instr[20:16];
    end
  end

  // Operand outputs change only in READ and hold otherwise.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_a <= '0;
      r_b <= '0;
    end else if (r_state == READ) begin
      r_a <= w_load_a;
      r_b <= w_load_b;
    end
  end

  // Registered valid: the pulse appears in the cycle following the DONE edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_valid <= 1'b0;
    else      r_valid <= (r_state == DONE);
  end

  assign A_out    = r_a;
  assign B_out    = r_b;
  assign rd_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_reg_read_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_read_unit
// Description : Self-checking bench for reg_read_unit: directed scenarios plus
//               randomized traffic against a timing/behaviour reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_read_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] instr = '0;
  logic        rd_req = 1'b0;
  logic        rd_ready;
  logic        rd_valid;
  logic [31:0] A_out;
  logic [31:0] B_out;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;

  int n_checks = 0;
  int n_errors = 0;

  reg_read_unit dut (
    .CLK      (CLK),
    .RST      (RST),
    .instr    (instr),
    .rd_req   (rd_req),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .A_out    (A_out),
    .B_out    (B_out),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  always #5 CLK = ~CLK;

`ifdef REG_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // Reference model: register contents, acceptance edge, expected outputs.
  logic [31:0] mdl [32];
  int          edges = 0;
  int          t_acc = -100;
  logic [4:0]  m_rs, m_rt;
  logic [31:0] exp_a, exp_b;
  logic        exp_valid, exp_ready;
  int          n_valid;

  always @(posedge CLK) if (RST) edges <= edges + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    t_acc = -100; m_rs = '0; m_rt = '0;
    exp_a = '0; exp_b = '0; exp_valid = 1'b0; exp_ready = 1'b1;
  endtask

  // One clock: check outputs at the falling edge, drive inputs, predict
  // what the next rising edge will produce.
  task automatic cycle(input logic req, input logic [31:0] ins, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd);
    int e;
    @(negedge CLK);
    check("rd_valid", {31'd0, rd_valid}, {31'd0, exp_valid});
    check("rd_ready", {31'd0, rd_ready}, {31'd0, exp_ready});
    check("A_out", A_out, exp_a);
    check("B_out", B_out, exp_b);
    if (rd_valid) n_valid++;
    rd_req = req; instr = ins; wr_en = we; wr_addr = wa; wr_data = wd;
    e = edges;
    exp_valid = (e == t_acc + 2);
    if (e == t_acc + 1) begin
      exp_a = (BYPASS && we && wa != 0 && wa == m_rs) ? wd : mdl[m_rs];
      exp_b = (BYPASS && we && wa != 0 && wa == m_rt) ? wd : mdl[m_rt];
    end
    if (req && e >= t_acc + 3) begin
      t_acc = e; m_rs = ins[25:21]; m_rt = ins[20:16];
    end
    if (we && wa != 0) mdl[wa] = wd;
    exp_ready = (e + 1 >= t_acc + 3);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, $urandom, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cycle(1'b0, $urandom, 1'b1, a, d);
  endtask

  // Issue a read and run until its rd_valid cycle has been checked.
  task automatic do_read(input logic [4:0] rs, input logic [4:0] rt);
    cycle(1'b1, {6'd0, rs, rt, 16'h0}, 1'b0, 5'd0, 32'd0);
    idle(3);
  endtask

  initial begin
    model_reset();
    n_valid = 0;
    #12;
    check("rst_A", A_out, 32'd0);
    check("rst_B", B_out, 32'd0);
    check("rst_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_ready", {31'd0, rd_ready}, 32'd1);
    @(negedge CLK); RST = 1'b1;

    // Basic read.
    wr(5'd5, 32'h1234);
    wr(5'd7, 32'hBEEF);
    do_read(5'd5, 5'd7);
    check("basic_valid", {31'd0, rd_valid}, 32'd1);
    check("basic_A", A_out, 32'h1234);
    check("basic_B", B_out, 32'hBEEF);

    // Zero register discards writes.
    wr(5'd0, 32'hFFFF_FFFF);
    do_read(5'd0, 5'd0);
    check("zero_A", A_out, 32'd0);

    // Selector targets.
    wr(5'd31, 32'hA5A5_0031);
    wr(5'd24, 32'h5A5A_0024);
    do_read(5'd31, 5'd24);
    check("ra_A", A_out, 32'hA5A5_0031);
    check("k_B", B_out, 32'h5A5A_0024);

    // Same-register read on both ports.
    do_read(5'd7, 5'd7);
    check("same_AB", A_out, B_out);
    check("same_B", B_out, 32'hBEEF);

    // Write during READ to a latched operand.
    wr(5'd3, 32'h11);
    cycle(1'b1, {6'd0, 5'd3, 5'd5, 16'h0}, 1'b0, 5'd0, 32'd0);
    cycle(1'b0, 32'd0, 1'b1, 5'd3, 32'h22);
    idle(2);
    check("bypass_A", A_out, BYPASS ? 32'h22 : 32'h11);
    do_read(5'd3, 5'd3);
    check("after_wr_A", A_out, 32'h22);

    // Held request: two results, instr scrambled while busy.
    n_valid = 0;
    for (int i = 0; i < 6; i++)
      cycle(1'b1, (i == 0 || i == 3) ? {6'd0, 5'd31, 5'd5, 16'h0} : $urandom,
            1'b0, 5'd0, 32'd0);
    idle(3);
    check("busy_pulses", n_valid, 32'd2);
    check("busy_A", A_out, 32'hA5A5_0031);

    // Reset during READ.
    cycle(1'b1, {6'd0, 5'd5, 5'd7, 16'h0}, 1'b0, 5'd0, 32'd0);
    @(posedge CLK); #2;
    rd_req = 1'b0;
    RST = 1'b0;
    #1;
    check("rstr_A", A_out, 32'd0);
    check("rstr_B", B_out, 32'd0);
    check("rstr_ready", {31'd0, rd_ready}, 32'd1);
    model_reset();
    n_valid = 0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    idle(4);
    check("rstr_pulses", n_valid, 32'd0);
    do_read(5'd5, 5'd24);
    check("rstr_cleared", A_out | B_out, 32'd0);

    // Randomized traffic; writes often target a pending operand index.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] wa;
      wa = ($urandom_range(0, 2) == 0) ? m_rs : 5'($urandom);
      cycle($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1, wa, $urandom);
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
